// File: rtl/cpu_core_pkg.sv
// Shared definitions for the Hack-style cpu_core: FSM states, instruction
// field positions and a small decode helper.
package cpu_core_pkg;

  localparam int DefaultWordSize = 16;

  localparam int INSTR_BIT = 15;
  localparam int A_BIT     = 12;
  localparam int COMP_HI   = 11;
  localparam int COMP_LO   = 6;
  localparam int DEST_A    = 5;
  localparam int DEST_D    = 4;
  localparam int DEST_M    = 3;
  localparam int JLT       = 2;
  localparam int JEQ       = 1;
  localparam int JGT       = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // A C-instruction whose y operand comes from memory needs a load first
  function automatic logic needs_read(input logic [15:0] instr);
    return instr[INSTR_BIT] & instr[A_BIT];
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Hack ALU: optional zero/negate on each operand, add or and, optional
// negate of the result, plus zero and negative flags.
module alu
  import cpu_core_pkg::*;
#(
  parameter int WordSize = DefaultWordSize
) (
  input  logic [WordSize-1:0] x,
  input  logic [WordSize-1:0] y,
  input  logic                zx,
  input  logic                nx,
  input  logic                zy,
  input  logic                ny,
  input  logic                f,
  input  logic                no,
  output logic [WordSize-1:0] out,
  output logic                zr,
  output logic                ng
);

  logic [WordSize-1:0] xs;
  logic [WordSize-1:0] ys;
  logic [WordSize-1:0] fo;

  always_comb begin
    xs = zx ? '0 : x;
    if (nx) xs = ~xs;
    ys = zy ? '0 : y;
    if (ny) ys = ~ys;
    fo = f ? (xs + ys) : (xs & ys);
    out = no ? ~fo : fo;
  end

  assign zr = (out == '0);
  assign ng = out[WordSize-1];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle Hack CPU: fetch/read/exec/write FSM driving an ALU, with
// instruction and data memories behind req/ack handshakes.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int WordSize = DefaultWordSize
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WordSize-1:0] dmem_addr,
  output logic [WordSize-1:0] dmem_wdata,
  input  logic                dmem_ack,
  input  logic [WordSize-1:0] dmem_rdata,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] a_reg,
  output logic [WordSize-1:0] d_reg,
  output logic                retire
);

  state_t              state;
  logic [15:0]         ir;
  logic [WordSize-1:0] m_latch;
  logic [WordSize-1:0] y_in;
  logic [WordSize-1:0] alu_out;
  logic                zr;
  logic                ng;
  logic                jump;

  assign imem_addr = pc;
  assign y_in      = ir[A_BIT] ? m_latch : a_reg;

  alu #(.WordSize(WordSize)) u_alu (
    .x   (d_reg),
    .y   (y_in),
    .zx  (ir[COMP_HI]),
    .nx  (ir[COMP_HI-1]),
    .zy  (ir[COMP_HI-2]),
    .ny  (ir[COMP_HI-3]),
    .f   (ir[COMP_LO+1]),
    .no  (ir[COMP_LO]),
    .out (alu_out),
    .zr  (zr),
    .ng  (ng)
  );

  assign jump = (ir[JLT] & ng) | (ir[JEQ] & zr) | (ir[JGT] & ~ng & ~zr);

  // a_reg still holds A_old during EXEC, so jump target and store address use it directly
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      ir         <= '0;
      m_latch    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      retire     <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            if (needs_read(imem_data)) begin
              dmem_req  <= 1'b1;
              dmem_we   <= 1'b0;
              dmem_addr <= a_reg;
              state     <= READ;
            end else begin
              state <= EXEC;
            end
          end
        end
        READ: begin
          if (dmem_ack) begin
            m_latch  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (!ir[INSTR_BIT]) begin
            a_reg    <= WordSize'(ir[14:0]);
            pc       <= pc + WordSize'(1);
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else begin
            if (ir[DEST_A]) a_reg <= alu_out;
            if (ir[DEST_D]) d_reg <= alu_out;
            pc <= jump ? a_reg : pc + WordSize'(1);
            if (ir[DEST_M]) begin
              dmem_addr  <= a_reg;
              dmem_wdata <= alu_out;
              dmem_req   <= 1'b1;
              dmem_we    <= 1'b1;
              state      <= WRITE;
            end else begin
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        WRITE: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: memory responders with configurable or random wait
// states, and an instruction-level Hack model checked at every retire.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = 16'h0;
  logic [15:0] pc;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        retire;

  cpu_core #(.WordSize(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .a_reg      (a_reg),
    .d_reg      (d_reg),
    .retire     (retire)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // bench-controlled knobs (written only by the main initial block)
  bit          force_acks = 1'b1;
  bit          late_ack = 1'b0;
  bit          rand_mode = 1'b0;
  int          cfg_iwait = 0;
  int          cfg_dwait = 0;
  logic [31:0] seed = 32'h0;
  logic [15:0] prog [logic [15:0]];
  logic [15:0] dmem_pre [logic [15:0]];

  // responder-owned memory and store log
  logic [15:0] dmem_mem [logic [15:0]];
  int          st_count = 0;
  logic [15:0] last_st_addr = 16'h0;
  logic [15:0] last_st_data = 16'h0;
  int          icnt = 0;
  int          dcnt = 0;
  int          iwait_cur = 0;
  int          dwait_cur = 0;

  // model state (main initial block only)
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_a = 16'h0;
  logic [15:0] m_d = 16'h0;
  int          m_st_count = 0;
  logic [15:0] model_mem [logic [15:0]];

  function automatic logic [15:0] dmemDefault(input logic [15:0] a);
    return (a * 16'h6D2B) ^ 16'h5A17;
  endfunction

  function automatic logic [15:0] genInstr(input logic [15:0] a);
    logic [31:0] h;
    h = ({16'h0, a} ^ seed) * 32'h9E3779B1;
    h = h ^ (h >> 16);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    if (h[31:30] == 2'b00) return {1'b0, h[14:0]};
    return {3'b111, h[12:0]};
  endfunction

  function automatic logic [15:0] fetchWord(input logic [15:0] a);
    return prog.exists(a) ? prog[a] : genInstr(a);
  endfunction

  function automatic logic [15:0] benchRead(input logic [15:0] a);
    if (dmem_mem.exists(a)) return dmem_mem[a];
    if (dmem_pre.exists(a)) return dmem_pre[a];
    return dmemDefault(a);
  endfunction

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    if (dmem_pre.exists(a)) return dmem_pre[a];
    return dmemDefault(a);
  endfunction

  // Hack ALU semantics in unsigned arithmetic: bitwise not is 65535 - v
  function automatic logic [15:0] aluModel(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    int unsigned xv, yv, r;
    xv = c[5] ? 0 : int'(x);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : int'(y);
    if (c[2]) yv = 65535 - yv;
    r = c[1] ? (xv + yv) % 65536 : (xv & yv);
    if (c[0]) r = 65535 - r;
    return r[15:0];
  endfunction

  // Memory responders act 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (force_acks) begin
      imem_ack   = 1'b1;
      imem_data  = 16'h0;
      dmem_ack   = 1'b1;
      dmem_rdata = 16'h0;
    end else begin
      if (imem_req) begin
        if (icnt == 0) iwait_cur = rand_mode ? int'($urandom_range(0, 2)) : cfg_iwait;
        if (icnt >= iwait_cur) begin
          imem_ack  = 1'b1;
          imem_data = fetchWord(imem_addr);
        end else begin
          imem_ack  = 1'b0;
          imem_data = 16'($urandom);
        end
        icnt++;
      end else begin
        imem_ack = 1'b0;
        icnt = 0;
      end
      if (dmem_req) begin
        if (dcnt == 0) dwait_cur = rand_mode ? int'($urandom_range(0, 2)) : cfg_dwait;
        if (dcnt >= dwait_cur) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            dmem_mem[dmem_addr] = dmem_wdata;
            st_count++;
            last_st_addr = dmem_addr;
            last_st_data = dmem_wdata;
          end else begin
            dmem_rdata = benchRead(dmem_addr);
          end
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = 16'($urandom);
        end
        dcnt++;
      end else begin
        dmem_ack = 1'b0;
        dcnt = 0;
      end
      if (late_ack) dmem_ack = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit force_a, input bit late, input int dwait);
    reset      = rst;
    force_acks = force_a;
    late_ack   = late;
    cfg_dwait  = dwait;
  endtask

  task automatic modelReset();
    m_pc = 16'h0;
    m_a  = 16'h0;
    m_d  = 16'h0;
  endtask

  // Wait for the next retire, execute one instruction in the model and compare
  task automatic waitRetire(input int budget, input bit timed);
    int          cyc;
    bit          seen;
    bit          rd, st, lt, eq, gt, jmp;
    logic [15:0] ins, y, res, old_a;
    int          expc;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (retire) begin
        seen = 1'b1;
        ins  = fetchWord(m_pc);
        rd   = 1'b0;
        st   = 1'b0;
        res  = 16'h0;
        old_a = m_a;
        if (!ins[15]) begin
          m_a  = {1'b0, ins[14:0]};
          m_pc = m_pc + 16'd1;
        end else begin
          rd  = ins[12];
          y   = rd ? modelRead(m_a) : m_a;
          res = aluModel(m_d, y, ins[11:6]);
          lt  = $signed(res) < 0;
          eq  = (res == 16'h0);
          gt  = $signed(res) > 0;
          jmp = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
          if (ins[5]) m_a = res;
          if (ins[4]) m_d = res;
          st = ins[3];
          if (st) begin
            model_mem[old_a] = res;
            m_st_count++;
          end
          m_pc = jmp ? old_a : m_pc + 16'd1;
        end
        checkOutput("pc", pc, m_pc);
        checkOutput("a_reg", a_reg, m_a);
        checkOutput("d_reg", d_reg, m_d);
        if (st) begin
          checkOutput("store_count", st_count, m_st_count);
          checkOutput("store_addr", last_st_addr, old_a);
          checkOutput("store_data", last_st_data, res);
        end
        if (imem_req) checkOutput("imem_addr", imem_addr, m_pc);
        expc = 2 + cfg_iwait + (rd ? 1 + cfg_dwait : 0) + (st ? 1 + cfg_dwait : 0);
        if (timed && !rand_mode) checkOutput("retire_spacing", cyc, expc);
      end else begin
        if (imem_req) checkOutput("imem_addr", imem_addr, m_pc);
        if (dmem_req && !dmem_we) checkOutput("load_addr", dmem_addr, m_a);
      end
    end
    if (!seen) checkOutput("retire_seen", retire, 1'b1);
  endtask

  initial begin
    seed = $urandom;
    prog[16'd0]   = 16'h0005;
    prog[16'd1]   = 16'hEC10;
    prog[16'd2]   = 16'h0010;
    prog[16'd3]   = 16'hFC10;
    prog[16'd4]   = 16'h0009;
    prog[16'd5]   = 16'hEC10;
    prog[16'd6]   = 16'h0007;
    prog[16'd7]   = 16'hE7E8;
    prog[16'd8]   = 16'h0064;
    prog[16'd9]   = 16'hEA90;
    prog[16'd10]  = 16'hE302;
    prog[16'd100] = 16'hEE90;
    prog[16'd101] = 16'hE301;
    prog[16'd102] = 16'h0032;
    prog[16'd103] = 16'hE308;
    dmem_pre[16'h0010] = 16'h1234;

    // reset with acks held high
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pc", pc, 16'h0);
    checkOutput("rst_a", a_reg, 16'h0);
    checkOutput("rst_d", d_reg, 16'h0);
    checkOutput("rst_imem_req", imem_req, 1'b0);
    checkOutput("rst_dmem_req", dmem_req, 1'b0);
    @(negedge clk);
    checkOutput("rst2_imem_req", imem_req, 1'b0);
    checkOutput("rst2_dmem_we", dmem_we, 1'b0);
    checkOutput("rst2_retire", retire, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    modelReset();
    @(negedge clk);
    checkOutput("post_rst_imem_req", imem_req, 1'b1);
    checkOutput("post_rst_imem_addr", imem_addr, 16'h0);

    // register path
    waitRetire(20, 1'b0);
    waitRetire(20, 1'b1);
    checkOutput("t2_a", a_reg, 16'd5);
    checkOutput("t2_d", d_reg, 16'd5);
    checkOutput("t2_pc", pc, 16'd2);

    // load with two wait states
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    waitRetire(20, 1'b1);
    waitRetire(20, 1'b1);
    checkOutput("t3_d", d_reg, 16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);

    // store uses the old A
    for (int i = 0; i < 4; i++) waitRetire(20, 1'b1);
    checkOutput("t4_st_addr", last_st_addr, 16'h0007);
    checkOutput("t4_st_data", last_st_data, 16'h000A);
    checkOutput("t4_a", a_reg, 16'h000A);

    // jumps
    for (int i = 0; i < 3; i++) waitRetire(20, 1'b1);
    checkOutput("t5_jeq_pc", pc, 16'd100);
    waitRetire(20, 1'b1);
    waitRetire(20, 1'b1);
    checkOutput("t5_jgt_pc", pc, 16'd102);
    checkOutput("t5_d", d_reg, 16'hFFFF);

    // reset while a store is waiting for its ack
    applyStimulus(1'b0, 1'b0, 1'b0, 1000);
    waitRetire(20, 1'b1);
    for (int i = 0; i < 10 && !(dmem_req && dmem_we); i++) @(negedge clk);
    checkOutput("t6_write_req", dmem_req & dmem_we, 1'b1);
    checkOutput("t6_wr_addr", dmem_addr, 16'd50);
    checkOutput("t6_wr_data", dmem_wdata, 16'hFFFF);
    @(negedge clk);
    checkOutput("t6_wait_retire", retire, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 0);
    checkOutput("t6_dmem_req", dmem_req, 1'b0);
    checkOutput("t6_pc", pc, 16'h0);
    checkOutput("t6_retire", retire, 1'b0);
    modelReset();
    @(negedge clk);
    checkOutput("t6_late_dmem_req", dmem_req, 1'b0);
    checkOutput("t6_late_retire", retire, 1'b0);
    checkOutput("t6_no_store", st_count, m_st_count);
    @(negedge clk);
    checkOutput("t6_late_retire2", retire, 1'b0);
    checkOutput("t6_late_d", d_reg, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    waitRetire(20, 1'b0);
    checkOutput("t6_resume_a", a_reg, 16'd5);

    // random programs with random wait states
    rand_mode = 1'b1;
    prog.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    modelReset();
    for (int i = 0; i < 400; i++) waitRetire(60, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Multi-cycle Hack-style CPU datapath and control. It is the stage directly upstream and downstream of the `alu`:
- upstream: it fetches and decodes 16-bit instructions and drives the `alu` x/y operands and the six control bits;
- downstream: it consumes `alu` out/zr/ng to update the A and D registers, store to data memory and resolve jumps.

Instruction and data memories sit outside the block behind req/ack handshakes.

## Interface
- `WordSize`, default `DefaultWordSize` (16): data/address width; must be ≥16. Instructions are always 16 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out WordSize: fetch address, equal to pc.
- `imem_ack` in 1: `imem_data` valid this cycle.
- `imem_data` in 16: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out WordSize: data address.
- `dmem_wdata` out WordSize: store data.
- `dmem_ack` in 1: access complete; `dmem_rdata` valid when `dmem_we`=0.
- `dmem_rdata` in WordSize: load data.
- `pc` out WordSize, `a_reg` out WordSize, `d_reg` out WordSize: architectural state.
- `retire` out 1: one-cycle pulse when an instruction completes.

## Operation
**Decode**
- ir[15]=0 is an A-instruction. It loads A with ir[14:0], zero-extended.
- ir[15]=1 is a C-instruction; ir[14:13] are ignored. Fields:
  - a = ir[12]
  - zx,nx,zy,ny,f,no = ir[11:6]
  - d1(A),d2(D),d3(M) = ir[5:3]
  - j1(lt),j2(eq),j3(gt) = ir[2:0]
- ALU x = D. ALU y = a ? M latch : A.
- Jump taken = j1&ng | j2&zr | j3&~ng&~zr.

**FSM states**
- FETCH:
  - Assert `imem_req`; `imem_addr` = pc.
  - On `imem_ack`, latch ir.
  - Next state: READ if C-instruction with a=1, else EXEC.
- READ:
  - Assert `dmem_req` with `dmem_we`=0 and `dmem_addr` = A.
  - On `dmem_ack`, latch `dmem_rdata` into the M latch and go to EXEC.
- EXEC (exactly one cycle):
  - A-instruction: A ← ir[14:0]; pc ← pc+1; go to FETCH; pulse `retire`.
  - C-instruction:
    - If d1, A ← out. If d2, D ← out.
    - pc ← jump ? A_old : pc+1.
    - If d3, latch store address = A_old and store data = out, then go to WRITE.
    - Otherwise go to FETCH and pulse `retire`.
  - A_old is the value of A before this cycle's update. It is used for both the jump target and the store address.
- WRITE:
  - Assert `dmem_req` with `dmem_we`=1 and the latched address and data.
  - On `dmem_ack`, pulse `retire` and go to FETCH.

**Handshake rules**
- A req stays high, with address, we and wdata stable, until ack is sampled high.
- Ack in the same cycle req rises is legal (zero-wait).
- Ack while req is low is ignored.
- Each request is followed by at least one cycle with req low before the next request.

**Arithmetic**
- pc+1 wraps modulo 2^WordSize.
- ALU add wraps; there is no carry out.

## Timing
- Reset values (state after a reset edge):
  - pc, A, D, ir, M latch, store latches = 0.
  - State = FETCH.
  - `imem_req`, `dmem_req`, `dmem_we`, `retire` = 0 in the cycle after reset.
  - `imem_req` rises in the first cycle with reset low.
- Minimum cycles per instruction, zero-wait memories:
  - A-instruction or register-only C-instruction: 2.
  - C-instruction with M read: 3.
  - C-instruction with store: 3.
  - C-instruction with both: 4.
- Each memory wait cycle adds one cycle.
- `retire` is registered and is high for exactly one cycle per instruction.
- Reset mid-operation (any state, req outstanding): abort at the reset edge. No architectural update from the aborted instruction. req drops. A late ack is ignored.
- A write to A and a jump in the same instruction: the jump uses A_old.

## Structure
- const.h gains:
  - FSM state encodings (FETCH, READ, EXEC, WRITE);
  - instruction field bit positions (A_BIT=12, COMP_HI=11, COMP_LO=6, DEST_A=5, DEST_D=4, DEST_M=3, JLT=2, JEQ=1, JGT=0).
- One sub-module: instantiate `alu` with `WordSize` passed through.
- Jump logic, registers and FSM stay inline.

## Test plan
1. **Reset.** Assert reset for 2 cycles with acks held high.
   - Expect pc=0, a_reg=0, d_reg=0 and all reqs low.
   - After release, expect `imem_req`=1 with `imem_addr`=0.
2. **Register path.** Program 0x0005 (@5), 0xEC10 (D=A), zero-wait.
   - Expect a_reg=5, d_reg=5, pc=2.
   - Expect two `retire` pulses, 2 cycles apart.
3. **Load with wait states.** Program @16, then 0xFC10 (D=M). `dmem_rdata`=0x1234, ack delayed 2 cycles.
   - `dmem_addr`=0x0010 and `dmem_we`=0 must stay stable during the wait.
   - Expect d_reg=0x1234.
4. **Store uses old A.** With D=9, program @7, then 0xE7E8 (AM=D+1).
   - Expect a store to address 7 with data 0x000A.
   - Expect a_reg=0x000A afterwards.
5. **Jumps.**
   - Program @100, 0xEA90 (D=0), 0xE302 (D;JEQ): expect pc=100.
   - With D=0xFFFF, 0xE301 (D;JGT): expect pc = previous pc+1.
6. **Reset mid-store.** In WRITE with ack withheld, pulse reset for 1 cycle.
   - Expect `dmem_req` low the next cycle, pc=0, and no `retire`.
   - A subsequent ack has no effect.
